// File: rtl/bg_scroll_renderer.sv
// Scrolling, tiled background renderer: maps the current VGA pixel to a wrapped
// texel address, waits out the ROM/palette latency and emits a gated RGB pixel.
module bg_scroll_renderer #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int IDX_W       = 4,
    parameter int ROM_LAT     = 2
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic              enable,
    input  logic [9:0]        scroll_x,
    input  logic [9:0]        scroll_y,
    input  logic              scroll_wr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [11:0]       pal_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              scroll_err
);

    localparam logic [10:0] IMG_W_S = 11'(IMG_W);
    localparam logic [10:0] IMG_H_S = 11'(IMG_H);
    localparam logic [9:0]  IMG_W_P = 10'(IMG_W);
    localparam logic [9:0]  IMG_H_P = 10'(IMG_H);

    logic [9:0]        pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [9:0]        act_x_q, act_x_d, act_y_q, act_y_d;
    logic              scroll_err_q, scroll_err_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0]  blank_dly_q, blank_dly_d;
    logic [ROM_LAT:0]  en_dly_q, en_dly_d;
    logic [11:0]       rgb_q, rgb_d;

    logic              in_range, wr_ok;
    logic [9:0]        bx, by;
    logic [10:0]       sum_x, sum_y, sx, sy;

    // Scroll registers: pending is written any time, active only moves on frame_start.
    always_comb begin
        in_range     = (scroll_x < IMG_W_P) && (scroll_y < IMG_H_P);
        wr_ok        = scroll_wr && in_range;
        pend_x_d     = wr_ok ? scroll_x : pend_x_q;
        pend_y_d     = wr_ok ? scroll_y : pend_y_q;
        act_x_d      = act_x_q;
        act_y_d      = act_y_q;
        if (frame_start) begin
            act_x_d = wr_ok ? scroll_x : pend_x_q;
            act_y_d = wr_ok ? scroll_y : pend_y_q;
        end
        scroll_err_d = scroll_err_q | (scroll_wr & ~in_range);
    end

    // Both operands are below the image size, so one conditional subtract wraps.
    always_comb begin
        bx         = DrawX >> SCALE_SHIFT;
        by         = DrawY >> SCALE_SHIFT;
        sum_x      = {1'b0, bx} + {1'b0, act_x_q};
        sum_y      = {1'b0, by} + {1'b0, act_y_q};
        sx         = (sum_x >= IMG_W_S) ? (sum_x - IMG_W_S) : sum_x;
        sy         = (sum_y >= IMG_H_S) ? (sum_y - IMG_H_S) : sum_y;
        rom_addr_d = ADDR_W'(sy) * ADDR_W'(IMG_W) + ADDR_W'(sx);
    end

    always_comb begin
        blank_dly_d = {blank_dly_q[ROM_LAT-1:0], blank};
        en_dly_d    = {en_dly_q[ROM_LAT-1:0], enable};
        rgb_d       = (blank_dly_q[ROM_LAT] && en_dly_q[ROM_LAT]) ? pal_rgb : 12'h000;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            act_x_q      <= '0;
            act_y_q      <= '0;
            scroll_err_q <= 1'b0;
            rom_addr_q   <= '0;
            blank_dly_q  <= '0;
            en_dly_q     <= '0;
            rgb_q        <= '0;
        end else begin
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            scroll_err_q <= scroll_err_d;
            rom_addr_q   <= rom_addr_d;
            blank_dly_q  <= blank_dly_d;
            en_dly_q     <= en_dly_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pal_index  = rom_q;
    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign scroll_err = scroll_err_q;

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Bench for bg_scroll_renderer: directed pixels with hand-computed addresses,
// a 2-cycle ROM model and a combinational palette, checked through expected queues.
module tb_bg_scroll_renderer;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY, scroll_x, scroll_y;
    logic        blank, frame_start, enable, scroll_wr;
    logic [14:0] rom_addr;
    logic [3:0]  rom_q, pal_index;
    logic [11:0] pal_rgb;
    logic [3:0]  red, green, blue;
    logic        scroll_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [14:0] exp_addr_q[$];
    int          due_addr_q[$];
    logic [11:0] exp_rgb_q[$];
    int          due_rgb_q[$];

    bg_scroll_renderer dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .enable(enable),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .scroll_wr(scroll_wr),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
        .pal_rgb(pal_rgb), .red(red), .green(green), .blue(blue),
        .scroll_err(scroll_err)
    );

    // ---- clock / reset block ----
    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

    // ---- external ROM (2-cycle latency) and palette models ----
    function automatic logic [3:0] rom_fn(input logic [14:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]};
    endfunction

    function automatic logic [11:0] pal_fn(input logic [3:0] i);
        return {i, ~i, i + 4'd5};
    endfunction

    logic [3:0] rom_p1 = '0;
    logic [3:0] rom_p2 = '0;
    always @(posedge vga_clk) begin
        rom_p1 <= rom_fn(rom_addr);
        rom_p2 <= rom_p1;
    end
    assign rom_q   = rom_p2;
    assign pal_rgb = pal_fn(pal_index);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- driver tasks ----
    task automatic pix(input int x, input int y, input logic b, input logic e,
                       input logic [14:0] ea);
        @(negedge vga_clk);
        DrawX  = 10'(x);
        DrawY  = 10'(y);
        blank  = b;
        enable = e;
        exp_addr_q.push_back(ea);
        due_addr_q.push_back(cyc + 1);
        exp_rgb_q.push_back((b && e) ? pal_fn(rom_fn(ea)) : 12'h000);
        due_rgb_q.push_back(cyc + 4);
    endtask

    task automatic wr(input int x, input int y, input logic with_fs);
        @(negedge vga_clk);
        scroll_x    = 10'(x);
        scroll_y    = 10'(y);
        scroll_wr   = 1'b1;
        frame_start = with_fs;
        @(negedge vga_clk);
        scroll_wr   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fs();
        @(negedge vga_clk);
        frame_start = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (due_addr_q.size() > 0 || due_rgb_q.size() > 0); i++)
            @(negedge vga_clk);
        if (due_addr_q.size() > 0 || due_rgb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries pending required 0",
                     due_addr_q.size() + due_rgb_q.size());
            exp_addr_q.delete(); due_addr_q.delete();
            exp_rgb_q.delete();  due_rgb_q.delete();
        end
    endtask

    // ---- scoreboard monitor ----
    initial begin
        logic [14:0] ea;
        logic [11:0] er;
        int          d;
        forever begin
            @(negedge vga_clk);
            while (due_addr_q.size() > 0 && due_addr_q[0] <= cyc) begin
                d  = due_addr_q.pop_front();
                ea = exp_addr_q.pop_front();
                check("rom_addr", {17'd0, rom_addr}, {17'd0, ea});
            end
            while (due_rgb_q.size() > 0 && due_rgb_q[0] <= cyc) begin
                d  = due_rgb_q.pop_front();
                er = exp_rgb_q.pop_front();
                check("rgb", {20'd0, red, green, blue}, {20'd0, er});
            end
        end
    end

    // ---- directed sequence ----
    initial begin
        reset = 1'b1; DrawX = 10'd4; DrawY = 10'd8; blank = 1'b1; enable = 1'b1;
        frame_start = 1'b0; scroll_wr = 1'b0; scroll_x = '0; scroll_y = '0;
        repeat (3) @(negedge vga_clk);
        check("reset_addr", {17'd0, rom_addr}, 32'd0);
        check("reset_rgb", {20'd0, red, green, blue}, 32'd0);
        check("reset_err", {31'd0, scroll_err}, 32'd0);
        blank = 1'b0;
        reset = 1'b0;

        // scroll 0, basic mapping and back-to-back throughput
        pix(4, 8, 1'b1, 1'b1, 15'd321);
        pix(0, 0, 1'b1, 1'b1, 15'd0);
        pix(639, 479, 1'b1, 1'b1, 15'd19199);
        drain();

        // double buffering and X wrap
        wr(159, 0, 1'b0);
        pix(4, 0, 1'b1, 1'b1, 15'd1);
        fs();
        pix(4, 0, 1'b1, 1'b1, 15'd0);
        pix(0, 0, 1'b1, 1'b1, 15'd159);
        pix(639, 0, 1'b1, 1'b1, 15'd158);
        drain();

        // Y wrap
        wr(0, 119, 1'b0);
        fs();
        pix(8, 476, 1'b1, 1'b1, 15'd18882);
        pix(8, 0, 1'b1, 1'b1, 15'd19042);
        drain();
        check("err_after_valid", {31'd0, scroll_err}, 32'd0);

        // out-of-range writes are dropped and flagged
        wr(200, 5, 1'b0);
        check("err_set", {31'd0, scroll_err}, 32'd1);
        fs();
        pix(8, 476, 1'b1, 1'b1, 15'd18882);
        wr(5, 130, 1'b0);
        fs();
        pix(8, 0, 1'b1, 1'b1, 15'd19042);
        drain();
        check("err_held", {31'd0, scroll_err}, 32'd1);

        // last write wins
        wr(3, 0, 1'b0);
        wr(7, 1, 1'b0);
        pix(0, 0, 1'b1, 1'b1, 15'd19040);
        fs();
        pix(0, 0, 1'b1, 1'b1, 15'd167);
        drain();

        // write-through
        wr(10, 0, 1'b1);
        pix(0, 0, 1'b1, 1'b1, 15'd10);
        drain();

        // blank / enable gating, address path keeps running
        pix(4, 0, 1'b1, 1'b1, 15'd11);
        pix(8, 0, 1'b0, 1'b1, 15'd12);
        pix(12, 0, 1'b1, 1'b1, 15'd13);
        pix(16, 0, 1'b1, 1'b0, 15'd14);
        pix(20, 0, 1'b1, 1'b1, 15'd15);
        drain();
        check("err_still_held", {31'd0, scroll_err}, 32'd1);

        // asynchronous reset mid-line
        pix(40, 0, 1'b1, 1'b1, 15'd20);
        drain();
        @(posedge vga_clk);
        #2;
        reset = 1'b1;
        #1;
        check("midline_rgb", {20'd0, red, green, blue}, 32'd0);
        check("midline_addr", {17'd0, rom_addr}, 32'd0);
        check("midline_err", {31'd0, scroll_err}, 32'd0);
        blank = 1'b0;
        @(negedge vga_clk);
        reset = 1'b0;

        // first visible pixel no earlier than four cycles after release
        pix(4, 8, 1'b1, 1'b1, 15'd321);
        for (int i = 1; i <= 3; i++) begin
            @(negedge vga_clk);
            check("post_reset_black", {20'd0, red, green, blue}, 32'd0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
